// File: rtl/mix_col_engine.sv
// AES MixColumns / InvMixColumns engine: latches a 128-bit state, transforms
// COLS_PER_CYCLE columns per cycle in place, then holds the result until taken.
module mix_col_engine #(
   parameter int COLS_PER_CYCLE = 1,
   parameter bit INV_EN         = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam int         NUM_CYC  = 4 / COLS_PER_CYCLE;
   localparam logic [1:0] CNT_LAST = 2'(NUM_CYC - 1);

   generate
      if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
         $error("mix_col_engine: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, COMPUTE, DONE} fsm_t;

   fsm_t         fsm_q, fsm_d;
   logic         armed_q;
   logic [1:0]   cnt_q;
   logic         mode_q;
   logic [127:0] state_q, state_d;
   logic         accept;
   logic         cnt_last;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_fwd(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // The inverse matrix factors as the forward matrix times [5 0 4 0; 0 5 0 4; ...],
   // so InvMixColumns = mix_fwd(inv_pre(c)) and shares the forward datapath.
   function automatic logic [31:0] inv_pre(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3, u, v;
      {a0, a1, a2, a3} = c;
      u = xtime(xtime(a0 ^ a2));
      v = xtime(xtime(a1 ^ a3));
      return {a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v};
   endfunction

   logic [1:0]  col_idx [COLS_PER_CYCLE];
   logic [31:0] col_res [COLS_PER_CYCLE];

   for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
      logic [31:0] src, pre;
      assign col_idx[k] = 2'(32'(cnt_q) * COLS_PER_CYCLE + k);
      assign src        = state_q[col_idx[k]*32 +: 32];
      if (INV_EN) begin : g_inv
         assign pre = mode_q ? inv_pre(src) : src;
      end else begin : g_fwd_only
         assign pre = src;
      end
      assign col_res[k] = mix_fwd(pre);
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         state_d[col_idx[k]*32 +: 32] = col_res[k];
      end
   end

   assign accept   = in_valid & in_ready;
   assign cnt_last = (cnt_q == CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q   <= IDLE;
         armed_q <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         armed_q <= 1'b1;
      end
   end

   always_comb begin
      fsm_d = fsm_q;
      case (fsm_q)
         IDLE:    if (accept)    fsm_d = COMPUTE;
         COMPUTE: if (cnt_last)  fsm_d = DONE;
         DONE:    if (out_ready) fsm_d = IDLE;
         default:                fsm_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (fsm_q == IDLE) && armed_q;
      out_valid = (fsm_q == DONE);
      busy      = (fsm_q != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= '0;
         mode_q  <= 1'b0;
         cnt_q   <= 2'd0;
      end else if (accept) begin
         state_q <= in_state;
         mode_q  <= in_mode & INV_EN;
         cnt_q   <= 2'd0;
      end else if (fsm_q == COMPUTE) begin
         state_q <= state_d;
         cnt_q   <= cnt_last ? 2'd0 : cnt_q + 2'd1;
      end
   end

   assign out_state = state_q;

endmodule

// File: tb/tb_mix_col_engine.sv
// Directed bench for mix_col_engine: four instances (1, 2 and 4 columns per cycle,
// plus a forward-only build) share stimulus and are checked against known AES vectors.
module tb_mix_col_engine;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_mode = 1'b0;
   logic         out_ready = 1'b0;
   logic [127:0] in_state = '0;

   logic         in_ready_w  [4];
   logic         out_valid_w [4];
   logic         busy_w      [4];
   logic [127:0] out_state_w [4];

   int           errors = 0;
   int           checks = 0;
   logic [127:0] res [4];
   int           lat [4];

   always #5 clk = ~clk;

   mix_col_engine #(.COLS_PER_CYCLE(1), .INV_EN(1)) u_c1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid_w[0]),
      .out_ready(out_ready), .out_state(out_state_w[0]), .busy(busy_w[0]));

   mix_col_engine #(.COLS_PER_CYCLE(2), .INV_EN(1)) u_c2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid_w[1]),
      .out_ready(out_ready), .out_state(out_state_w[1]), .busy(busy_w[1]));

   mix_col_engine #(.COLS_PER_CYCLE(4), .INV_EN(1)) u_c4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[2]),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid_w[2]),
      .out_ready(out_ready), .out_state(out_state_w[2]), .busy(busy_w[2]));

   mix_col_engine #(.COLS_PER_CYCLE(1), .INV_EN(0)) u_fwd (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[3]),
      .in_state(in_state), .in_mode(in_mode), .out_valid(out_valid_w[3]),
      .out_ready(out_ready), .out_state(out_state_w[3]), .busy(busy_w[3]));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] rep(input logic [31:0] c);
      return {4{c}};
   endfunction

   function automatic logic [11:0] flags();
      return {in_ready_w[0], in_ready_w[1], in_ready_w[2], in_ready_w[3],
              out_valid_w[0], out_valid_w[1], out_valid_w[2], out_valid_w[3],
              busy_w[0], busy_w[1], busy_w[2], busy_w[3]};
   endfunction

   // Checks results of instances 0..n-1 against one expected state.
   task automatic check_res(input string tag, input int n, input logic [127:0] exp);
      for (int i = 0; i < n; i++) check($sformatf("%s_u%0d", tag, i), res[i], exp);
   endtask

   // One transaction on all instances; disturb drives a conflicting offer after accept,
   // hold keeps out_ready low for that many cycles once every instance is in DONE.
   task automatic run(input logic [127:0] st, input logic md, input bit disturb, input int hold);
      bit all_done;
      bit stable;
      @(negedge clk);
      check("ready_before_accept", flags(), 12'hf00);
      in_valid = 1'b1;
      in_state = st;
      in_mode  = md;
      for (int i = 0; i < 4; i++) begin
         lat[i] = 0;
         res[i] = '0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (disturb) begin
         in_valid = 1'b1;
         in_mode  = ~md;
         in_state = ~st;
      end
      all_done = 1'b0;
      for (int cyc = 1; cyc <= 20 && !all_done; cyc++) begin
         @(posedge clk); #1;
         all_done = 1'b1;
         for (int i = 0; i < 4; i++) begin
            if (lat[i] == 0 && out_valid_w[i]) begin
               lat[i] = cyc;
               res[i] = out_state_w[i];
            end
            if (lat[i] == 0) all_done = 1'b0;
         end
      end
      if (!all_done) check("out_valid_timeout", 1'b0, 1'b1);
      if (hold > 0) begin
         stable = 1'b1;
         for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++)
               if (out_state_w[i] !== res[i] || in_ready_w[i] !== 1'b0 || out_valid_w[i] !== 1'b1)
                  stable = 1'b0;
         end
         check("done_hold_stable", stable, 1'b1);
      end
      @(negedge clk);
      in_valid  = 1'b0;
      in_mode   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("idle_after_ack", flags(), 12'hf00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [127:0] x, y;
      bit           quiet;

      #12;
      check("reset_flags", flags(), 12'h000);
      check("reset_out_state", out_state_w[0] | out_state_w[1] | out_state_w[2] | out_state_w[3], '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("ready_low_before_edge", flags(), 12'h000);
      @(posedge clk); #1;
      check("ready_after_first_edge", flags(), 12'hf00);

      run(rep(32'hdb135345), 1'b0, 1'b0, 0);
      check_res("fwd_db13", 4, rep(32'h8e4da1bc));
      check("latency", {lat[0][7:0], lat[1][7:0], lat[2][7:0], lat[3][7:0]}, 32'h04020104);

      run(rep(32'hf20a225c), 1'b0, 1'b0, 0);
      check_res("fwd_f20a", 4, rep(32'h9fdc589d));
      run(rep(32'hd4d4d4d5), 1'b0, 1'b0, 0);
      check_res("fwd_d4d4", 4, rep(32'hd5d5d7d6));

      run({32'h01010101, 32'hd4d4d4d5, 32'hf20a225c, 32'hdb135345}, 1'b0, 1'b0, 0);
      check_res("fwd_mixed", 4, {32'h01010101, 32'hd5d5d7d6, 32'h9fdc589d, 32'h8e4da1bc});

      run(rep(32'h8e4da1bc), 1'b1, 1'b0, 0);
      check_res("inv_8e4d", 3, rep(32'hdb135345));
      run({32'h01010101, 32'hd5d5d7d6, 32'h9fdc589d, 32'h8e4da1bc}, 1'b1, 1'b0, 0);
      check_res("inv_mixed", 3, {32'h01010101, 32'hd4d4d4d5, 32'hf20a225c, 32'hdb135345});

      run(rep(32'h01010101), 1'b0, 1'b0, 0);
      check_res("fwd_0101", 4, rep(32'h01010101));
      run(rep(32'h01010101), 1'b1, 1'b0, 0);
      check_res("inv_0101", 4, rep(32'h01010101));
      run(rep(32'hc6c6c6c6), 1'b0, 1'b0, 0);
      check_res("fwd_c6c6", 4, rep(32'hc6c6c6c6));
      run(rep(32'hc6c6c6c6), 1'b1, 1'b0, 0);
      check_res("inv_c6c6", 4, rep(32'hc6c6c6c6));

      run(rep(32'hdb135345), 1'b1, 1'b0, 0);
      check("fwd_only_ignores_mode", res[3], rep(32'h8e4da1bc));

      run(rep(32'hdb135345), 1'b0, 1'b1, 10);
      check_res("latched_fwd_disturbed", 4, rep(32'h8e4da1bc));
      run(rep(32'h8e4da1bc), 1'b1, 1'b1, 0);
      check_res("latched_inv_disturbed", 3, rep(32'hdb135345));

      // Reset while u_c1/u_c2 are computing and u_c4 already sits in DONE.
      @(negedge clk);
      in_valid = 1'b1;
      in_state = rep(32'hf20a225c);
      in_mode  = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1 check("mid_reset_flags", flags(), 12'h000);
      check("mid_reset_out_state", out_state_w[0] | out_state_w[2], '0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("mid_reset_ready_low", flags(), 12'h000);
      quiet = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (flags() !== 12'hf00) quiet = 1'b0;
      end
      check("no_result_after_reset", quiet, 1'b1);
      run(rep(32'hf20a225c), 1'b0, 1'b0, 0);
      check_res("after_reset_fwd", 4, rep(32'h9fdc589d));

      for (int n = 0; n < 1000; n++) begin
         x = {$urandom, $urandom, $urandom, $urandom};
         run(x, 1'b0, 1'b0, 0);
         y = res[0];
         run(y, 1'b1, 1'b0, 0);
         check_res($sformatf("roundtrip_%0d", n), 3, x);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
